mips_multicycle_ctrl: RTL

- Parametrised multi-cycle successor to the single-cycle MIPS control segment.
- Sequences each instruction through IF/ID/EX/MEM/WB states using a registered IR, A, B, ALUOut and MDR.
- Drives the existing instruction memory, register file, ALU and data memory interfaces.
- Sits between those blocks and replaces the single-cycle PC/control glue.

---
 rtl/mips_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control: steps each instruction through IF/ID/EX/MEM/WB using registered IR, A, B, ALUOut, MDR.
// Optional macro MEM_WAIT_EN adds a dm_ready input that stretches the MEM state until memory is ready.
module mips_multicycle_ctrl #(
    parameter int IM_AW = 5,
    parameter int DM_AW = 5,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    output logic [IM_AW-1:0] im_addr,
    output logic [4:0]       r1_addr,
    output logic [4:0]       r2_addr,
    output logic [4:0]       r3_addr,
    output logic [31:0]      r3_in,
    output logic             r3_we,
    input  logic [31:0]      r1_out,
    input  logic [31:0]      r2_out,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_op,
    input  logic [31:0]      alu_out,
    input  logic             zero,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_d,
    output logic             dm_we,
    input  logic [31:0]      dm_spo,
`ifdef MEM_WAIT_EN
    input  logic             dm_ready,
`endif
    output logic [2:0]       state
);

    generate
        if (DW != 32) begin : g_dw_check
            $error("mips_multicycle_ctrl: DW must be 32 for the MIPS encoding");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        I_NOP,
        I_RTYPE,
        I_LW,
        I_SW,
        I_BEQ,
        I_ADDI,
        I_J
    } kind_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_e            state_q, state_d;
    logic [IM_AW-1:0]  pc_q, pc_d;
    logic [DW-1:0]     ir_q, ir_d;
    logic [DW-1:0]     a_q, a_d;
    logic [DW-1:0]     b_q, b_d;
    logic [DW-1:0]     alu_out_q, alu_out_d;
    logic [DW-1:0]     mdr_q, mdr_d;

    kind_e             kind;
    logic [2:0]        r_alu_op;
    logic [DW-1:0]     imm_sext;
    logic              mem_ready;

`ifdef MEM_WAIT_EN
    assign mem_ready = dm_ready;
`else
    assign mem_ready = 1'b1;
`endif

    // Instruction class from the registered IR; unknown opcodes and functs collapse to NOP.
    always_comb begin
        kind     = I_NOP;
        r_alu_op = ALU_AND;
        case (ir_q[31:26])
            6'b000000: begin
                kind = I_RTYPE;
                case (ir_q[5:0])
                    6'b100000: r_alu_op = ALU_ADD;
                    6'b100010: r_alu_op = ALU_SUB;
                    6'b100100: r_alu_op = ALU_AND;
                    6'b100101: r_alu_op = ALU_OR;
                    6'b101010: r_alu_op = ALU_SLT;
                    default:   kind     = I_NOP;
                endcase
            end
            6'b100011: kind = I_LW;
            6'b101011: kind = I_SW;
            6'b000100: kind = I_BEQ;
            6'b001000: kind = I_ADDI;
            6'b000010: kind = I_J;
            default:   kind = I_NOP;
        endcase
    end

    assign imm_sext = {{(DW-16){ir_q[15]}}, ir_q[15:0]};

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = ALU_AND;
        dm_we     = 1'b0;
        r3_we     = 1'b0;

        case (state_q)
            S_IF: begin
                ir_d    = instr;
                pc_d    = pc_q + IM_AW'(1);
                state_d = S_ID;
            end
            S_ID: begin
                a_d = r1_out;
                b_d = r2_out;
                case (kind)
                    I_J: begin
                        pc_d    = ir_q[IM_AW-1:0];
                        state_d = S_IF;
                    end
                    I_NOP:   state_d = S_IF;
                    default: state_d = S_EX;
                endcase
            end
            S_EX: begin
                alu_a     = a_q;
                alu_b     = (kind == I_LW || kind == I_SW || kind == I_ADDI) ? imm_sext : b_q;
                alu_op    = (kind == I_RTYPE) ? r_alu_op :
                            (kind == I_BEQ)   ? ALU_SUB  : ALU_ADD;
                alu_out_d = alu_out;
                case (kind)
                    I_BEQ: begin
                        // PC already points past the branch, so the offset is relative to PC+1.
                        if (zero) pc_d = pc_q + imm_sext[IM_AW-1:0];
                        state_d = S_IF;
                    end
                    I_LW, I_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dm_we = (kind == I_SW);
                if (mem_ready) begin
                    if (kind == I_LW) begin
                        mdr_d   = dm_spo;
                        state_d = S_WB;
                    end else begin
                        state_d = S_IF;
                    end
                end
            end
            S_WB: begin
                r3_we   = (r3_addr != 5'd0);
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
        end
    end

    assign im_addr = pc_q;
    assign r1_addr = ir_q[25:21];
    assign r2_addr = ir_q[20:16];
    assign r3_addr = (kind == I_RTYPE) ? ir_q[15:11] : ir_q[20:16];
    assign r3_in   = (kind == I_LW) ? mdr_q : alu_out_q;
    assign dm_addr = alu_out_q[DM_AW+1:2];
    assign dm_d    = b_q;
    assign state   = state_q;

endmodule
